// File: rtl/tdc_pkg.sv
// Shared TDC definitions for the TOA/TOT encoder paths.
// Holds the delay-line geometry, the coarse-selection window that keeps the
// counter choice away from the ripple-counter transition points, and the
// fixed edge values fed into the bubble filter at both ends of the line.
package tdc_pkg;

  localparam int TAPS   = 63;
  localparam int FINE_W = 6;
  localparam int CNT_W  = 3;

  // Fine codes inside [16, 47] are far from both counter increments, so
  // counter A is trusted there; outside it counter B is used instead.
  localparam logic [FINE_W-1:0] COARSE_WIN_LO = 6'd16;
  localparam logic [FINE_W-1:0] COARSE_WIN_HI = 6'd47;

  // Virtual tap below bit 0 reads as filled, virtual tap above the last
  // reads as empty, matching a thermometer that fills from bit 0 upward.
  localparam logic BC_LOW_BOUND  = 1'b1;
  localparam logic BC_HIGH_BOUND = 1'b0;

endpackage

// File: rtl/toa_bubble_corr.sv
// Combinational three-tap majority filter for thermometer words.
// Each output bit is the majority of itself and its two neighbours, which
// removes isolated single-bit holes and isolated stray ones.
// Ports:
//   raw        - N-bit thermometer as latched from the delay line
//   corrected  - N-bit filtered thermometer
module toa_bubble_corr
  import tdc_pkg::*;
#(
  parameter int N = TAPS
) (
  input  logic [N-1:0] raw,
  output logic [N-1:0] corrected
);

  logic [N+1:0] ext;

  assign ext = {BC_HIGH_BOUND, raw, BC_LOW_BOUND};

  // ext[i+1] is raw[i]; ext[i] and ext[i+2] are its lower and upper neighbours.
  always_comb begin
    corrected = '0;
    for (int i = 0; i < N; i++) begin
      corrected[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
    end
  end

endmodule

// File: rtl/toa_encoder.sv
// Three-stage TOA encoder sitting behind the TOA data latch.
// S1 captures the hit, S2 bubble-corrects the fine thermometer, S3 reduces
// it to a binary fine code, picks a safe coarse count and raises error flags.
// One hit per clock, fixed three-cycle latency, no backpressure.
// Ports:
//   clk, rstn        - encoder clock (posedge), async active-low reset
//   Data_Valid_In    - one-cycle hit strobe qualifying the data inputs
//   TOA_Fine_In      - 63-tap fine thermometer, fills from bit 0
//   TOA_CntA_In/B_In - ripple counters incremented at tap 0 / tap 32
//   TOA_Code         - {coarse, fine}
//   TOA_Fine_Code    - binary fine code 0..63
//   TOA_Coarse       - selected coarse count
//   Bubble_Err       - corrected word still not a clean thermometer
//   Cnt_Err          - counters A and B disagree beyond one count
//   Code_Valid       - outputs carry a new result this cycle
module toa_encoder
  import tdc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Data_Valid_In,
  input  logic [TAPS-1:0]         TOA_Fine_In,
  input  logic [CNT_W-1:0]        TOA_CntA_In,
  input  logic [CNT_W-1:0]        TOA_CntB_In,
  output logic [CNT_W+FINE_W-1:0] TOA_Code,
  output logic [FINE_W-1:0]       TOA_Fine_Code,
  output logic [CNT_W-1:0]        TOA_Coarse,
  output logic                    Bubble_Err,
  output logic                    Cnt_Err,
  output logic                    Code_Valid
);

  logic             s1_valid;
  logic [TAPS-1:0]  s1_fine;
  logic [CNT_W-1:0] s1_cnt_a;
  logic [CNT_W-1:0] s1_cnt_b;

  logic             s2_valid;
  logic [TAPS-1:0]  s2_fine;
  logic [CNT_W-1:0] s2_cnt_a;
  logic [CNT_W-1:0] s2_cnt_b;

  logic [TAPS-1:0]   corr_fine;
  logic [FINE_W-1:0] fine_sum;
  logic [TAPS:0]     therm_ext;
  logic [TAPS:0]     therm_inc;
  logic              bubble_det;
  logic [CNT_W-1:0]  coarse_sel;
  logic              cnt_mismatch;

  // S1: the valid bit shifts every cycle, data only loads on a strobe so
  // the captured word stays put between hits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_fine  <= '0;
      s1_cnt_a <= '0;
      s1_cnt_b <= '0;
    end else begin
      s1_valid <= Data_Valid_In;
      if (Data_Valid_In) begin
        s1_fine  <= TOA_Fine_In;
        s1_cnt_a <= TOA_CntA_In;
        s1_cnt_b <= TOA_CntB_In;
      end
    end
  end

  toa_bubble_corr #(.N(TAPS)) u_bubble_corr (
    .raw       (s1_fine),
    .corrected (corr_fine)
  );

  // S2: register the corrected thermometer alongside its counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_fine  <= '0;
      s2_cnt_a <= '0;
      s2_cnt_b <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_fine  <= corr_fine;
        s2_cnt_a <= s1_cnt_a;
        s2_cnt_b <= s1_cnt_b;
      end
    end
  end

  // Ones count of the corrected word; at most 63 so it fits FINE_W bits.
  always_comb begin
    fine_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      fine_sum = fine_sum + FINE_W'(s2_fine[i]);
    end
  end

  // A clean thermometer is 2^k-1, whose bits never overlap those of its
  // successor; any overlap means a zero sits below a one.
  assign therm_ext  = {1'b0, s2_fine};
  assign therm_inc  = therm_ext + 1'b1;
  assign bubble_det = |(therm_ext & therm_inc);

  // Near the tap-0 crossing counter A may be mid-toggle, so use B, which
  // has not yet seen this period's tap-32 edge when fine is small.
  always_comb begin
    coarse_sel = s2_cnt_b;
    if (fine_sum < COARSE_WIN_LO) begin
      coarse_sel = s2_cnt_b + CNT_W'(1);
    end else if (fine_sum <= COARSE_WIN_HI) begin
      coarse_sel = s2_cnt_a;
    end
  end

  assign cnt_mismatch = (s2_cnt_b != s2_cnt_a) && (s2_cnt_b != (s2_cnt_a - CNT_W'(1)));

  // S3: outputs update only for a valid hit and otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      Code_Valid    <= 1'b0;
      TOA_Code      <= '0;
      TOA_Fine_Code <= '0;
      TOA_Coarse    <= '0;
      Bubble_Err    <= 1'b0;
      Cnt_Err       <= 1'b0;
    end else begin
      Code_Valid <= s2_valid;
      if (s2_valid) begin
        TOA_Code      <= {coarse_sel, fine_sum};
        TOA_Fine_Code <= fine_sum;
        TOA_Coarse    <= coarse_sel;
        Bubble_Err    <= bubble_det;
        Cnt_Err       <= cnt_mismatch;
      end
    end
  end

endmodule

// File: tb/tb_toa_encoder.sv
// Directed self-checking bench for toa_encoder.
module tb_toa_encoder;

  logic        clk;
  logic        rstn;
  logic        Data_Valid_In;
  logic [62:0] TOA_Fine_In;
  logic [2:0]  TOA_CntA_In;
  logic [2:0]  TOA_CntB_In;
  logic [8:0]  TOA_Code;
  logic [5:0]  TOA_Fine_Code;
  logic [2:0]  TOA_Coarse;
  logic        Bubble_Err;
  logic        Cnt_Err;
  logic        Code_Valid;

  int tests_run = 0;
  int tests_failed = 0;

  toa_encoder dut (
    .clk           (clk),
    .rstn          (rstn),
    .Data_Valid_In (Data_Valid_In),
    .TOA_Fine_In   (TOA_Fine_In),
    .TOA_CntA_In   (TOA_CntA_In),
    .TOA_CntB_In   (TOA_CntB_In),
    .TOA_Code      (TOA_Code),
    .TOA_Fine_Code (TOA_Fine_Code),
    .TOA_Coarse    (TOA_Coarse),
    .Bubble_Err    (Bubble_Err),
    .Cnt_Err       (Cnt_Err),
    .Code_Valid    (Code_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Thermometer word with the lowest k taps set.
  function automatic logic [62:0] therm(input int k);
    logic [63:0] w;
    w = (64'd1 << k) - 64'd1;
    return w[62:0];
  endfunction

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs starting at a falling edge.
  task automatic apply_stimulus(input logic valid, input logic [62:0] fine, input logic [2:0] a, input logic [2:0] b);
    Data_Valid_In = valid;
    TOA_Fine_In   = fine;
    TOA_CntA_In   = a;
    TOA_CntB_In   = b;
    @(negedge clk);
    Data_Valid_In = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [5:0] fine, input logic [2:0] coarse,
                              input logic [8:0] code, input logic bub, input logic cnt);
    check_output({tag, ".valid"},  16'(Code_Valid),    16'd1);
    check_output({tag, ".fine"},   16'(TOA_Fine_Code), 16'(fine));
    check_output({tag, ".coarse"}, 16'(TOA_Coarse),    16'(coarse));
    check_output({tag, ".code"},   16'(TOA_Code),      16'(code));
    check_output({tag, ".bub"},    16'(Bubble_Err),    16'(bub));
    check_output({tag, ".cnt"},    16'(Cnt_Err),       16'(cnt));
  endtask

  // Single hit: check latency (not valid after two edges) then the result.
  task automatic single_hit(input string tag, input logic [62:0] fine_in, input logic [2:0] a, input logic [2:0] b,
                            input logic [5:0] fine, input logic [2:0] coarse, input logic [8:0] code,
                            input logic bub, input logic cnt);
    apply_stimulus(1'b1, fine_in, a, b);
    @(negedge clk);
    check_output({tag, ".early"}, 16'(Code_Valid), 16'd0);
    @(negedge clk);
    check_result(tag, fine, coarse, code, bub, cnt);
    @(negedge clk);
    check_output({tag, ".drop"}, 16'(Code_Valid), 16'd0);
    check_output({tag, ".hold"}, 16'(TOA_Code), 16'(code));
  endtask

  logic [62:0] stream_fine [5];
  logic [5:0]  stream_exp_fine [5];
  logic [2:0]  stream_exp_coarse [5];
  logic [8:0]  stream_exp_code [5];

  initial begin
    rstn          = 1'b1;
    Data_Valid_In = 1'b0;
    TOA_Fine_In   = '0;
    TOA_CntA_In   = '0;
    TOA_CntB_In   = '0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst.valid", 16'(Code_Valid), 16'd0);
    check_output("rst.code",  16'(TOA_Code),   16'd0);
    check_output("rst.fine",  16'(TOA_Fine_Code), 16'd0);
    check_output("rst.flags", 16'({Bubble_Err, Cnt_Err, TOA_Coarse}), 16'd0);
    rstn = 1'b1;
    @(negedge clk);

    single_hit("basic20", therm(20), 3'd3, 3'd3, 6'd20, 3'd3, 9'h0D4, 1'b0, 1'b0);
    single_hit("low5",    therm(5),  3'd4, 3'd3, 6'd5,  3'd4, 9'd261, 1'b0, 1'b0);
    single_hit("high50",  therm(50), 3'd5, 3'd4, 6'd50, 3'd4, 9'd306, 1'b0, 1'b0);
    single_hit("hole10",  therm(30) & ~(63'd1 << 10), 3'd3, 3'd3, 6'd30, 3'd3, 9'd222, 1'b0, 1'b0);
    single_hit("stray40", therm(30) | (63'd1 << 40),  3'd3, 3'd3, 6'd30, 3'd3, 9'd222, 1'b0, 1'b0);
    single_hit("f0f",     63'hF0F, 3'd3, 3'd3, 6'd8, 3'd4, 9'd264, 1'b1, 1'b0);
    single_hit("wrap",    therm(10), 3'd0, 3'd7, 6'd10, 3'd0, 9'd10, 1'b0, 1'b0);
    single_hit("cnterr",  therm(20), 3'd2, 3'd5, 6'd20, 3'd2, 9'd148, 1'b0, 1'b1);

    // Back-to-back hits around the coarse window edges; A=6, B=2 makes each
    // coarse source distinguishable (B+1=3, A=6, B=2).
    stream_fine[0] = therm(0);  stream_exp_fine[0] = 6'd0;  stream_exp_coarse[0] = 3'd3; stream_exp_code[0] = 9'd192;
    stream_fine[1] = therm(16); stream_exp_fine[1] = 6'd16; stream_exp_coarse[1] = 3'd6; stream_exp_code[1] = 9'd400;
    stream_fine[2] = therm(47); stream_exp_fine[2] = 6'd47; stream_exp_coarse[2] = 3'd6; stream_exp_code[2] = 9'd431;
    stream_fine[3] = therm(48); stream_exp_fine[3] = 6'd48; stream_exp_coarse[3] = 3'd2; stream_exp_code[3] = 9'd176;
    stream_fine[4] = therm(63); stream_exp_fine[4] = 6'd63; stream_exp_coarse[4] = 3'd2; stream_exp_code[4] = 9'd191;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) apply_stimulus(1'b1, stream_fine[i], 3'd6, 3'd2);
      else       apply_stimulus(1'b0, '0, 3'd0, 3'd0);
      if (i >= 2 && i < 7) begin
        check_result($sformatf("stream%0d", i - 2), stream_exp_fine[i-2], stream_exp_coarse[i-2],
                     stream_exp_code[i-2], 1'b0, 1'b1);
      end else begin
        check_output($sformatf("stream_idle%0d", i), 16'(Code_Valid), 16'd0);
      end
    end

    // Reset one cycle after a strobe: outputs clear at once, hit is lost,
    // and a strobe applied while reset is held is ignored too.
    apply_stimulus(1'b1, therm(20), 3'd3, 3'd3);
    rstn = 1'b0;
    #1;
    check_output("midrst.code",  16'(TOA_Code), 16'd0);
    check_output("midrst.fine",  16'(TOA_Fine_Code), 16'd0);
    check_output("midrst.flags", 16'({Bubble_Err, Cnt_Err, TOA_Coarse}), 16'd0);
    @(negedge clk);
    apply_stimulus(1'b1, therm(40), 3'd1, 3'd1);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output($sformatf("postrst%0d", i), 16'(Code_Valid), 16'd0);
    end

    single_hit("zeros", '0,        3'd1, 3'd1, 6'd0,  3'd2, 9'd128, 1'b0, 1'b0);
    single_hit("ones",  therm(63), 3'd1, 3'd1, 6'd63, 3'd1, 9'd127, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/toa_encoder.md
Name: toa_encoder

Overview:
- Pipelined encoder directly downstream of the TOA data latch in the ETROC2 TDC.
- Takes the latched 63-tap TOA fine-phase thermometer word and the two 3-bit ripple-counter values (A, B) and corrects bubbles.
- Converts the fine word to a 6-bit binary code, selects a metastability-safe coarse count and emits a 9-bit TOA code with error flags.
- Fully pipelined: accepts one hit per clock.

Parameters:
- TAPS, 63, number of delay-line taps in TOA_Fine_In
- FINE_W, 6, width of the binary fine code (must satisfy 2^FINE_W > TAPS)
- CNT_W, 3, ripple-counter width

Ports:
- clk  in  1  encoder clock (posedge)
- rstn  in  1  asynchronous active-low reset
- Data_Valid_In  in  1  one-cycle strobe; TOA_Fine_In/CntA_In/CntB_In are stable and valid this cycle
- TOA_Fine_In  in  63  latched fine thermometer; bit 0 = first tap, ones fill from bit 0 upward
- TOA_CntA_In  in  3  ripple counter A; increments at tap-0 crossing
- TOA_CntB_In  in  3  ripple counter B; increments at tap-32 crossing
- TOA_Code  out  9  {coarse[2:0], fine[5:0]}
- TOA_Fine_Code  out  6  binary fine code, 0..63
- TOA_Coarse  out  3  selected coarse count
- Bubble_Err  out  1  corrected word still not a clean thermometer
- Cnt_Err  out  1  counters inconsistent
- Code_Valid  out  1  outputs valid this cycle

Behaviour:
- Reset (rstn low, async): all pipeline registers and all outputs are 0, including Code_Valid=0. Reset asserted mid-operation discards in-flight hits; no Code_Valid is produced for a hit accepted before or during reset.
- Pipeline, 3 cycles. A strobe at cycle N gives Code_Valid=1 at cycle N+3. Back-to-back strobes produce back-to-back results in order. No stall, no backpressure.
  - S1: register the inputs when Data_Valid_In=1. The valid bit always shifts; data registers load only on a strobe.
  - S2: bubble correction, c[i] = majority(b[i-1], b[i], b[i+1]), with boundary b[-1]=1 and b[63]=0. Register c, the counters and valid.
  - S3: fine = popcount(c), range 0..63. Register fine, coarse, flags and valid to the outputs.
- Bubble_Err=1 iff c contains any 0 at an index below a 1, i.e. more than one 1->0 transition or a leading 0 followed by ones. fine is still popcount(c).
- Coarse selection (mod-8 arithmetic):
  - fine in 16..47: coarse = CntA
  - fine < 16: coarse = CntB + 1
  - fine >= 48: coarse = CntB
- Cnt_Err=1 iff CntB != CntA and CntB != CntA - 1 (mod 8). Wrap is legal: A=0, B=7 gives no error.
- TOA_Code = {coarse, fine}. When fine = 63 (all ones) no carry into coarse; the value is passed as is.
- Outputs hold their last values while Code_Valid=0. Flags are only meaningful with Code_Valid=1.
- All-zero input: fine=0, Bubble_Err=0. All-ones input: fine=63, Bubble_Err=0.

Decomposition:
- Shared package tdc_pkg: TAPS, FINE_W, CNT_W, the coarse window bounds (16, 47) and the boundary constants for bubble correction.
- One sub-module is natural: toa_bubble_corr, a combinational majority filter over TAPS bits, reusable by the TOT path.
- The popcount stays inline as an adder tree in S3.

Test Plan:
- Reset, then one strobe with Fine = 2^20-1 (20 ones), A=3, B=3 -> three cycles later Code_Valid=1, fine=20, coarse=3, TOA_Code=0x0D4, both error flags 0.
- Fine = 2^5-1, A=4, B=3 -> fine=5, coarse=B+1=4, Cnt_Err=0. Repeat with fine=50 ones, A=5, B=4 -> coarse=4.
- Single bubble: 30 ones with bit 10 cleared -> corrected to fine=30, Bubble_Err=0. Isolated stray 1 at bit 40 above 30 ones -> removed, fine=30, Bubble_Err=0. Pattern 0x...F0F (two 1->0 transitions wider than one bit) -> Bubble_Err=1.
- Counter wrap: A=0, B=7, fine=10 -> coarse=0, Cnt_Err=0. A=2, B=5 -> Cnt_Err=1.
- Five consecutive strobes with fine = 0, 16, 47, 48, 63 -> five consecutive Code_Valid cycles, in order, with coarse source A only for 16 and 47.
- Assert rstn low one cycle after a strobe -> all outputs 0 immediately and no Code_Valid afterwards. Repeat with all-zeros and all-ones inputs -> fine 0 and 63, no flags.
